nco_multi: RTL

- Time-multiplexed multi-channel numerically controlled oscillator. Successor to the single-channel phase-to-amplitude DDS.
- Each channel has its own phase accumulator, frequency control word (FCW) and phase offset.
- A shared quarter-wave sine LUT (dual read port) produces sin and, optionally, cos per channel in round-robin order.
- Output is one AXI-Stream with backpressure, channel tag and frame-last. It sits between the control register bank and the digital mixers.

---
 rtl/nco_pkg.sv | 20 ++
 rtl/nco_multi_if.sv | 14 +
 rtl/nco_quarter_lut.sv | 56 +++++
 rtl/nco_multi.sv | 99 +++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel NCO and its quarter-wave LUT.
package nco_pkg;

   typedef logic [1:0] quad_t;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int peak_val(input int dw);
      return (1 << (dw - 1)) - 1;
   endfunction

   // Same formula the hex init file is defined by, so the table needs no external file.
   function automatic int lut_entry(input int i, input int idx_w, input int dw);
      return $rtoi(real'(peak_val(dw)) *
                   $sin(3.14159265358979323846 / 2.0 * real'(i) / real'(1 << idx_w)) + 0.5);
   endfunction

endpackage

// File: rtl/nco_multi_if.sv
// AXI-Stream sample bus between the NCO and the downstream mixers.
interface nco_multi_if #(
   parameter int OUT_DW = 16,
   parameter int CH_W   = 2
);
   logic [2*OUT_DW-1:0] tdata;
   logic [CH_W-1:0]     tuser;
   logic                tlast;
   logic                tvalid;
   logic                tready;

   modport master (output tdata, tuser, tlast, tvalid, input tready);
   modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/nco_quarter_lut.sv
// Two-port quarter-wave sine lookup: mirror/peak decode, synchronous table read, sign restore.
module nco_quarter_lut
   import nco_pkg::*;
#(
   parameter int PHASE_DW = 16,
   parameter int OUT_DW   = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic [1:0][PHASE_DW-1:0]  phase,
   output logic [1:0][OUT_DW-1:0]    amp
);
   localparam int IDX_W = PHASE_DW - 2;
   localparam int DEPTH = 1 << IDX_W;
   localparam logic [OUT_DW-1:0] PEAK = OUT_DW'(peak_val(OUT_DW));

   logic [OUT_DW-1:0] rom [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      assign rom[i] = OUT_DW'(lut_entry(i, IDX_W, OUT_DW));
   end

   for (genvar p = 0; p < 2; p++) begin : g_port
      quad_t             q;
      logic [IDX_W-1:0]  raw;
      logic [IDX_W-1:0]  idx;
      logic              peak1, neg1, neg2;
      logic [OUT_DW-1:0] mag, amp_r;

      assign q   = phase[p][PHASE_DW-1 -: 2];
      assign raw = phase[p][IDX_W-1:0];

      // Odd quadrants run the table backwards; index 0 there is the one point (full scale) not stored.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            idx   <= '0;
            peak1 <= 1'b0;
            neg1  <= 1'b0;
            mag   <= '0;
            neg2  <= 1'b0;
            amp_r <= '0;
         end else if (en) begin
            idx   <= q[0] ? -raw : raw;
            peak1 <= q[0] && (raw == '0);
            neg1  <= q[1];
            mag   <= peak1 ? PEAK : rom[idx];
            neg2  <= neg1;
            amp_r <= neg2 ? -mag : mag;
         end
      end

      assign amp[p] = amp_r;
   end

endmodule

// File: rtl/nco_multi.sv
// Time-multiplexed multi-channel NCO: per-channel accumulators issue round-robin into a shared
// sin/cos LUT pipeline, delivered on one AXI-Stream with channel tag and frame-last.
module nco_multi
   import nco_pkg::*;
#(
   parameter int PHASE_DW = 16,
   parameter int OUT_DW   = 16,
   parameter int NUM_CH   = 4,
   parameter int SIN_COS  = 1,
   localparam int CH_W    = ch_w(NUM_CH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                cfg_wr_en,
   input  logic [CH_W-1:0]     cfg_wr_ch,
   input  logic                cfg_wr_sel,
   input  logic [PHASE_DW-1:0] cfg_wr_data,
   input  logic                cfg_sync,
   nco_multi_if.master         m_axis
);
   localparam logic [PHASE_DW-1:0] QTR  = PHASE_DW'(1) << (PHASE_DW - 2);
   localparam logic [CH_W-1:0]     LAST = CH_W'(NUM_CH - 1);

   logic                             adv, issue;
   logic [CH_W-1:0]                  ch_cnt;
   logic [NUM_CH-1:0][PHASE_DW-1:0]  acc, fcw, off;
   logic [PHASE_DW-1:0]              s0_phase;
   logic [3:0]                       vld_pipe, last_pipe;
   logic [3:0][CH_W-1:0]             ch_pipe;
   logic [1:0][OUT_DW-1:0]           amp;

   assign adv   = !vld_pipe[3] || m_axis.tready;
   assign issue = adv && enable;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [PHASE_DW-1:0] acc_r, fcw_r, off_r;

      // Config writes are independent of backpressure; the issue slot reads the pre-write value.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            acc_r <= '0;
            fcw_r <= '0;
            off_r <= '0;
         end else begin
            if (cfg_sync)
               acc_r <= '0;
            else if (issue && ch_cnt == CH_W'(c))
               acc_r <= acc_r + fcw_r;
            if (cfg_wr_en && cfg_wr_ch == CH_W'(c)) begin
               if (cfg_wr_sel) off_r <= cfg_wr_data;
               else            fcw_r <= cfg_wr_data;
            end
         end
      end

      assign acc[c] = acc_r;
      assign fcw[c] = fcw_r;
      assign off[c] = off_r;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ch_cnt    <= '0;
         s0_phase  <= '0;
         vld_pipe  <= '0;
         last_pipe <= '0;
         ch_pipe   <= '0;
      end else begin
         if (adv) begin
            vld_pipe  <= {vld_pipe[2:0], enable};
            ch_pipe   <= {ch_pipe[2:0], ch_cnt};
            last_pipe <= {last_pipe[2:0], ch_cnt == LAST};
            if (enable) s0_phase <= acc[ch_cnt] + off[ch_cnt];
         end
         if (cfg_sync)
            ch_cnt <= '0;
         else if (issue)
            ch_cnt <= (ch_cnt == LAST) ? '0 : ch_cnt + CH_W'(1);
      end
   end

   nco_quarter_lut #(
      .PHASE_DW (PHASE_DW),
      .OUT_DW   (OUT_DW)
   ) u_lut (
      .clk   (clk),
      .reset (reset),
      .en    (adv),
      .phase ({s0_phase + QTR, s0_phase}),
      .amp   (amp)
   );

   assign m_axis.tdata  = {(SIN_COS != 0) ? amp[1] : OUT_DW'(0), amp[0]};
   assign m_axis.tuser  = ch_pipe[3];
   assign m_axis.tlast  = last_pipe[3];
   assign m_axis.tvalid = vld_pipe[3];

endmodule
